// File: rtl/oclib_pkg.sv
// Shared oclib constants used by the pipeline catcher and its helpers.
package oclib_pkg;

    localparam bit False = 1'b0;
    localparam bit True  = 1'b1;

endpackage

// File: rtl/oclib_fifo_ring.sv
// Circular buffer with arbitrary (non power-of-two) depth.
// Holds storage, pointers and occupancy; head reads zero when empty.
module oclib_fifo_ring
    import oclib_pkg::*;
#(
    parameter int Width         = 1,
    parameter int Depth         = 4,
    parameter bit ZeroWhenEmpty = True
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           head_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o;
    // A full buffer still accepts a push when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = next_ptr(wptr_q);
        if (do_pop)  rptr_d = next_ptr(rptr_q);
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

    assign head_o = (ZeroWhenEmpty && empty_o) ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/oclib_pipeline.sv
// Fixed-latency, stallless delay line of Length register stages.
module oclib_pipeline #(
    parameter int Width  = 1,
    parameter int Length = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    input  logic [Width-1:0] inData,
    output logic             outValid,
    output logic [Width-1:0] outData
);

    if (Length == 0) begin : g_wire
        assign outValid = inValid;
        assign outData  = inData;
    end else begin : g_pipe
        logic [Length-1:0] v_q;
        logic [Width-1:0]  d_q [Length];

        always_ff @(posedge clock) begin
            if (reset) begin
                v_q <= '0;
            end else begin
                v_q[0] <= inValid;
                for (int i = 1; i < Length; i++) v_q[i] <= v_q[i-1];
            end
        end

        always_ff @(posedge clock) begin
            d_q[0] <= inData;
            for (int i = 1; i < Length; i++) d_q[i] <= d_q[i-1];
        end

        assign outValid = v_q[Length-1];
        assign outData  = d_q[Length-1];
    end

endmodule

// File: rtl/oclib_pipeline_catcher.sv
// Credit-based catcher for a fixed-latency pipeline feeding a valid/ready stream.
// Define OCLIB_PIPELINE_CATCHER_BYPASS_EN for a same-cycle path when empty.
module oclib_pipeline_catcher
    import oclib_pkg::*;
#(
    parameter int Width = 1,
    parameter int Depth = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       launchReady,
    input  logic                       launch,
    input  logic                       inValid,
    input  logic [Width-1:0]           inData,
    output logic                       outValid,
    output logic [Width-1:0]           outData,
    input  logic                       outReady,
    output logic [$clog2(Depth+1)-1:0] occupancy,
    output logic                       error
);

    localparam int CntW = $clog2(Depth + 1);

    logic [CntW-1:0]  credits_q, credits_d;
    logic             ready_q;
    logic             error_q, error_d;
    logic             f_push, f_pop, f_full, f_empty;
    logic [Width-1:0] f_head;
    logic             take, pop;

    oclib_fifo_ring #(
        .Width        (Width),
        .Depth        (Depth),
        .ZeroWhenEmpty(True)
    ) u_ring (
        .clock      (clock),
        .reset      (reset),
        .push_i     (f_push),
        .push_data_i(inData),
        .pop_i      (f_pop),
        .head_o     (f_head),
        .count_o    (occupancy),
        .full_o     (f_full),
        .empty_o    (f_empty)
    );

`ifdef OCLIB_PIPELINE_CATCHER_BYPASS_EN
    logic bypass;
    assign bypass   = f_empty && inValid;
    assign outValid = bypass || !f_empty;
    assign outData  = bypass ? inData : f_head;
    assign f_push   = inValid && !(bypass && outReady);
`else
    assign outValid = !f_empty;
    assign outData  = f_head;
    assign f_push   = inValid;
`endif

    assign f_pop = outReady && !f_empty;
    assign pop   = outValid && outReady;
    assign take  = launch && ready_q;

    always_comb begin
        credits_d = credits_q;
        if (take && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (pop && !take && credits_q != CntW'(Depth)) begin
            // Saturate: beats injected without a credit must not wrap the count.
            credits_d = credits_q + 1'b1;
        end
        error_d = error_q
                | (launch && !ready_q)
                | (inValid && f_full && !f_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            credits_q <= CntW'(Depth);
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
        end else begin
            credits_q <= credits_d;
            ready_q   <= (credits_d != '0);
            error_q   <= error_d;
        end
    end

    assign launchReady = ready_q;
    assign error       = error_q;

endmodule
